// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// protocol byte constants and the "non-key byte" classifier.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // Keyboard housekeeping replies that never represent a key on their own.
    function automatic logic is_non_key(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser for a raw PS/2 line with an optional run-length
// de-glitch filter and a one-cycle falling-edge strobe.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8,
    parameter bit FILTER_EN  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_i};
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            logic [FILTER_LEN-1:0] shift_q;
            logic                  filt_q;
            logic                  filt_d;

            // Level changes only after FILTER_LEN identical samples, otherwise holds.
            always_comb begin
                filt_d = filt_q;
                if (&shift_q) begin
                    filt_d = 1'b1;
                end else if (~|shift_q) begin
                    filt_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shift_q <= '1;
                    filt_q  <= 1'b1;
                    fall_q  <= 1'b0;
                end else begin
                    shift_q <= {shift_q[FILTER_LEN-2:0], sync_q[1]};
                    filt_q  <= filt_d;
                    fall_q  <= filt_q & ~filt_d;
                end
            end

            assign level_o = filt_q;
        end else begin : g_nofilter
            logic prev_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q <= 1'b1;
                    fall_q <= 1'b0;
                end else begin
                    prev_q <= sync_q[1];
                    fall_q <= prev_q & ~sync_q[1];
                end
            end

            assign level_o = sync_q[1];
        end
    endgenerate

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: deserialises device-to-host frames and folds
// E0/F0 prefixes into single key events (code, extended, break).
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 200,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] raw_code,
    output logic       raw_ready,
    output logic       frame_err,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid
);

    localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);

    logic fall;
    logic clk_level_unused;
    logic data_s;
    logic data_fall_unused;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b1)) u_clk_filt (
        .clk     (clk),
        .rst_n   (rst),
        .line_i  (ps2_clk),
        .level_o (clk_level_unused),
        .fall_o  (fall)
    );

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b0)) u_data_sync (
        .clk     (clk),
        .rst_n   (rst),
        .line_i  (ps2_data),
        .level_o (data_s),
        .fall_o  (data_fall_unused)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    raw_code_q, raw_code_d;
    logic          raw_ready_q, raw_ready_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tmo_d       = '0;
        raw_code_d  = raw_code_q;
        raw_ready_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q != ST_IDLE) begin
            tmo_d = fall ? '0 : tmo_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall && !data_s) begin
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d  = {data_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    if ((^{shift_q, par_q}) && data_s) begin
                        raw_code_d  = shift_q;
                        raw_ready_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fall in the same cycle restarts the gap, so it takes priority.
        if (state_q != ST_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYC)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            tmo_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            raw_code_q  <= '0;
            raw_ready_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            raw_code_q  <= raw_code_d;
            raw_ready_q <= raw_ready_d;
            frame_err_q <= frame_err_d;
        end
    end

    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic [7:0] key_code_q, key_code_d;
    logic       key_ext_q, key_ext_d;
    logic       key_break_q, key_break_d;
    logic       key_valid_q, key_valid_d;

    always_comb begin
        ext_pend_d  = ext_pend_q;
        brk_pend_d  = brk_pend_q;
        key_code_d  = key_code_q;
        key_ext_d   = key_ext_q;
        key_break_d = key_break_q;
        key_valid_d = 1'b0;

        if (frame_err_q) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (raw_ready_q) begin
            if (raw_code_q == PS2_EXT) begin
                ext_pend_d = 1'b1;
            end else if (raw_code_q == PS2_BRK) begin
                brk_pend_d = 1'b1;
            end else if (!(is_non_key(raw_code_q) && !ext_pend_q && !brk_pend_q)) begin
                key_code_d  = raw_code_q;
                key_ext_d   = ext_pend_q;
                key_break_d = brk_pend_q;
                key_valid_d = 1'b1;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
            key_code_q  <= key_code_d;
            key_ext_q   <= key_ext_d;
            key_break_q <= key_break_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign raw_code  = raw_code_q;
    assign raw_ready = raw_ready_q;
    assign frame_err = frame_err_q;
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign key_valid = key_valid_q;

endmodule
